// File: rtl/pz_shadow_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : pz_shadow_regfile_if
// Purpose  : AXI-Lite bus bundle between the PS master and the pole/zero
//            shadow register file.
// Ports    : master modport drives AW/W/AR channels and B/R ready;
//            slave modport drives the ready signals and the B/R channels.
// Revision : 1.0 - initial release
// ============================================================================
interface pz_shadow_regfile_if #(
    parameter int AXI_LITE_ADDR_WIDTH = 8
);
    logic [AXI_LITE_ADDR_WIDTH-1:0] awaddr;
    logic                           awvalid;
    logic                           awready;
    logic [31:0]                    wdata;
    logic [3:0]                     wstrb;
    logic                           wvalid;
    logic                           wready;
    logic [1:0]                     bresp;
    logic                           bvalid;
    logic                           bready;
    logic [AXI_LITE_ADDR_WIDTH-1:0] araddr;
    logic                           arvalid;
    logic                           arready;
    logic [31:0]                    rdata;
    logic [1:0]                     rresp;
    logic                           rvalid;
    logic                           rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/pz_shadow_regfile.sv
`default_nettype none
// ============================================================================
// Module   : pz_shadow_regfile
// Purpose  : AXI-Lite register file with NUM_ZEROES zero and NUM_POLES pole
//            coefficients. Writes land in shadow registers; the active copy
//            driven to the pixel pipeline is updated atomically on a commit
//            (frame_done while commit_en and pending, or a force_commit).
// Ports    : clk, reset (sync, active-high)
//            s_axi_lite   - AXI-Lite slave bundle (pz_shadow_regfile_if.slave)
//            frame_done   - end-of-frame pulse
//            zeroes_out   - active zeroes, channel k at [32k+:32]
//            poles_out    - active poles, channel k at [32k+:32]
//            commit_pulse - high the cycle after each commit
// Config   : define PZREG_COMMIT_CNT_EN to add a 16-bit commit counter
//            readable in STATUS[31:16] (reads 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module pz_shadow_regfile #(
    parameter int NUM_ZEROES          = 4,
    parameter int NUM_POLES           = 4,
    parameter int AXI_LITE_ADDR_WIDTH = 8
) (
    input  wire                       clk,
    input  wire                       reset,
    pz_shadow_regfile_if.slave        s_axi_lite,
    input  wire                       frame_done,
    output logic [32*NUM_ZEROES-1:0]  zeroes_out,
    output logic [32*NUM_POLES-1:0]   poles_out,
    output logic                      commit_pulse
);
    localparam int          c_NUM_CH     = NUM_ZEROES + NUM_POLES;
    localparam int          c_IDX_W      = AXI_LITE_ADDR_WIDTH - 2;
    localparam logic [31:0] c_IDX_CTRL   = 32'(c_NUM_CH);
    localparam logic [31:0] c_IDX_STATUS = 32'(c_NUM_CH + 1);
    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;

    localparam logic [2:0] c_WR_IDLE      = 3'd0;
    localparam logic [2:0] c_WR_HAVE_ADDR = 3'd1;
    localparam logic [2:0] c_WR_HAVE_DATA = 3'd2;
    localparam logic [2:0] c_WR_WRITE     = 3'd3;
    localparam logic [2:0] c_WR_RESP      = 3'd4;

    localparam logic [1:0] c_RD_IDLE  = 2'd0;
    localparam logic [1:0] c_RD_FETCH = 2'd1;
    localparam logic [1:0] c_RD_DATA  = 2'd2;

    // ---------------- write channel ----------------
    logic [2:0]         r_wr_state;
    logic               r_awready, r_wready, r_bvalid;
    logic [1:0]         r_bresp;
    logic [c_IDX_W-1:0] r_wr_idx;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;

    logic        w_aw_hs, w_w_hs, w_wr_en;
    logic [31:0] w_wr_int;
    logic        w_wr_in_ch, w_wr_is_ctrl, w_wr_shadow, w_wr_ctrl;

    assign w_aw_hs      = r_awready & s_axi_lite.awvalid;
    assign w_w_hs       = r_wready & s_axi_lite.wvalid;
    assign w_wr_en      = (r_wr_state == c_WR_WRITE);
    assign w_wr_int     = 32'(r_wr_idx);
    assign w_wr_in_ch   = (w_wr_int < 32'(c_NUM_CH));
    assign w_wr_is_ctrl = (w_wr_int == c_IDX_CTRL);
    assign w_wr_shadow  = w_wr_en & w_wr_in_ch;
    assign w_wr_ctrl    = w_wr_en & w_wr_is_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= c_WR_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_RESP_OKAY;
            r_wr_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            case (r_wr_state)
                c_WR_IDLE: begin
                    // Readies come up one cycle after reset release.
                    r_awready <= 1'b1;
                    r_wready  <= 1'b1;
                    if (w_aw_hs) begin
                        r_wr_idx  <= s_axi_lite.awaddr[AXI_LITE_ADDR_WIDTH-1:2];
                        r_awready <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= s_axi_lite.wdata;
                        r_wstrb  <= s_axi_lite.wstrb;
                        r_wready <= 1'b0;
                    end
                    if (w_aw_hs && w_w_hs) r_wr_state <= c_WR_WRITE;
                    else if (w_aw_hs)      r_wr_state <= c_WR_HAVE_ADDR;
                    else if (w_w_hs)       r_wr_state <= c_WR_HAVE_DATA;
                end
                c_WR_HAVE_ADDR: begin
                    if (w_w_hs) begin
                        r_wdata    <= s_axi_lite.wdata;
                        r_wstrb    <= s_axi_lite.wstrb;
                        r_wready   <= 1'b0;
                        r_wr_state <= c_WR_WRITE;
                    end
                end
                c_WR_HAVE_DATA: begin
                    if (w_aw_hs) begin
                        r_wr_idx   <= s_axi_lite.awaddr[AXI_LITE_ADDR_WIDTH-1:2];
                        r_awready  <= 1'b0;
                        r_wr_state <= c_WR_WRITE;
                    end
                end
                c_WR_WRITE: begin
                    r_bvalid   <= 1'b1;
                    r_bresp    <= (w_wr_in_ch || w_wr_is_ctrl) ? c_RESP_OKAY : c_RESP_SLVERR;
                    r_wr_state <= c_WR_RESP;
                end
                c_WR_RESP: begin
                    if (s_axi_lite.bready) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_wr_state <= c_WR_IDLE;
                    end
                end
                default: r_wr_state <= c_WR_IDLE;
            endcase
        end
    end

    assign s_axi_lite.awready = r_awready;
    assign s_axi_lite.wready  = r_wready;
    assign s_axi_lite.bvalid  = r_bvalid;
    assign s_axi_lite.bresp   = r_bresp;

    // ---------------- control / commit ----------------
    logic        r_commit_en, r_force, r_pending, r_commit_pulse;
    logic        w_commit;
    logic [15:0] w_commit_cnt;

    assign w_commit = (frame_done & r_commit_en & r_pending) | r_force;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_commit_en    <= 1'b1;
            r_force        <= 1'b0;
            r_pending      <= 1'b0;
            r_commit_pulse <= 1'b0;
        end else begin
            r_commit_pulse <= w_commit;
            if (w_commit) begin
                r_pending <= 1'b0;
                r_force   <= 1'b0;
            end
            // A shadow write coinciding with a commit must survive to the next one.
            if (w_wr_shadow && (r_wstrb != 4'd0)) r_pending <= 1'b1;
            if (w_wr_ctrl && r_wstrb[0]) begin
                r_commit_en <= r_wdata[0];
                r_force     <= r_wdata[1];
            end
        end
    end

    assign commit_pulse = r_commit_pulse;

`ifdef PZREG_COMMIT_CNT_EN
    logic [15:0] r_commit_cnt;
    always_ff @(posedge clk) begin
        if (reset)         r_commit_cnt <= 16'd0;
        else if (w_commit) r_commit_cnt <= r_commit_cnt + 16'd1;
    end
    assign w_commit_cnt = r_commit_cnt;
`else
    assign w_commit_cnt = 16'd0;
`endif

    // ---------------- coefficient channels ----------------
    logic [31:0] w_shadow [c_NUM_CH];
    logic [31:0] w_active [c_NUM_CH];

    generate
        for (genvar k = 0; k < c_NUM_CH; k++) begin : g_ch
            localparam logic [31:0] c_K = 32'(k);
            logic [31:0] r_shadow;
            logic [31:0] r_active;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_shadow <= '0;
                    r_active <= '0;
                end else begin
                    // Non-blocking: a same-cycle write is seen by the next commit, not this one.
                    if (w_commit) r_active <= r_shadow;
                    if (w_wr_en && (w_wr_int == c_K)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (r_wstrb[b]) r_shadow[8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end
            assign w_shadow[k] = r_shadow;
            assign w_active[k] = r_active;
        end
        for (genvar k = 0; k < NUM_ZEROES; k++) begin : g_zero_out
            assign zeroes_out[32*k +: 32] = w_active[k];
        end
        for (genvar k = 0; k < NUM_POLES; k++) begin : g_pole_out
            assign poles_out[32*k +: 32] = w_active[NUM_ZEROES + k];
        end
    endgenerate

    // ---------------- read channel ----------------
    logic [1:0]         r_rd_state;
    logic               r_arready, r_rvalid;
    logic [c_IDX_W-1:0] r_rd_idx;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;
    logic [31:0]        w_rd_int, w_rd_data;
    logic               w_rd_err, w_ar_hs;

    assign w_ar_hs  = r_arready & s_axi_lite.arvalid;
    assign w_rd_int = 32'(r_rd_idx);

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (w_rd_int == c_IDX_CTRL) begin
            w_rd_data = {31'd0, r_commit_en};
        end else if (w_rd_int == c_IDX_STATUS) begin
            w_rd_data = {w_commit_cnt, 15'd0, r_pending};
        end else if (w_rd_int >= 32'(c_NUM_CH)) begin
            w_rd_err = 1'b1;
        end
        for (int k = 0; k < c_NUM_CH; k++) begin
            if (w_rd_int == 32'(k)) w_rd_data = w_shadow[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= c_RD_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rd_idx   <= '0;
            r_rdata    <= '0;
            r_rresp    <= c_RESP_OKAY;
        end else begin
            case (r_rd_state)
                c_RD_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_rd_idx   <= s_axi_lite.araddr[AXI_LITE_ADDR_WIDTH-1:2];
                        r_arready  <= 1'b0;
                        r_rd_state <= c_RD_FETCH;
                    end
                end
                c_RD_FETCH: begin
                    r_rdata    <= w_rd_data;
                    r_rresp    <= w_rd_err ? c_RESP_SLVERR : c_RESP_OKAY;
                    r_rvalid   <= 1'b1;
                    r_rd_state <= c_RD_DATA;
                end
                c_RD_DATA: begin
                    if (s_axi_lite.rready) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= c_RD_IDLE;
                    end
                end
                default: r_rd_state <= c_RD_IDLE;
            endcase
        end
    end

    assign s_axi_lite.arready = r_arready;
    assign s_axi_lite.rvalid  = r_rvalid;
    assign s_axi_lite.rdata   = r_rdata;
    assign s_axi_lite.rresp   = r_rresp;

    // Byte-lane address bits carry no register selection.
    logic w_unused;
    assign w_unused = ^{s_axi_lite.awaddr[1:0], s_axi_lite.araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_pz_shadow_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_pz_shadow_regfile
// Purpose  : Directed self-checking bench for pz_shadow_regfile (4 zeroes,
//            4 poles, 8-bit byte address). Drives the AXI-Lite bus through
//            the interface and checks shadow/active behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pz_shadow_regfile;
    localparam int c_AW = 8;
    localparam logic [7:0] c_A_Z0 = 8'h00;
    localparam logic [7:0] c_A_Z1 = 8'h04;
    localparam logic [7:0] c_A_P0 = 8'h10;
    localparam logic [7:0] c_A_CTRL = 8'h20;
    localparam logic [7:0] c_A_STATUS = 8'h24;
    localparam logic [7:0] c_A_BAD = 8'hFC;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_done;
    logic [127:0] zeroes_out;
    logic [127:0] poles_out;
    logic         commit_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    pz_shadow_regfile_if #(.AXI_LITE_ADDR_WIDTH(c_AW)) axi ();

    pz_shadow_regfile #(
        .NUM_ZEROES(4),
        .NUM_POLES(4),
        .AXI_LITE_ADDR_WIDTH(c_AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axi_lite   (axi.slave),
        .frame_done   (frame_done),
        .zeroes_out   (zeroes_out),
        .poles_out    (poles_out),
        .commit_pulse (commit_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (commit_pulse) n_pulses++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input logic pend, input logic [15:0] ncommit);
`ifdef PZREG_COMMIT_CNT_EN
        return {ncommit, 15'd0, pend};
`else
        return {ncommit & 16'h0000, 15'd0, pend};
`endif
    endfunction

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input bit take_b, output logic [1:0] resp);
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.awvalid = 1'b1;
        axi.wvalid  = (lead == 0);
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            @(negedge clk); cyc++;
            if (aw_hs) begin axi.awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin axi.wvalid  = 1'b0; w_done  = 1; end
            if (!w_done && cyc >= lead) axi.wvalid = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            check_val("wr_handshake_timeout", {30'd0, aw_done, w_done}, 32'd3);
            axi.awvalid = 1'b0;
            axi.wvalid  = 1'b0;
            resp = 2'b11;
            return;
        end
        axi.bready = take_b;
        cyc = 0;
        while (!axi.bvalid && cyc < 20) begin @(negedge clk); cyc++; end
        if (!axi.bvalid) check_val("bvalid_timeout", {31'd0, axi.bvalid}, 32'd1);
        resp = axi.bresp;
        if (take_b) begin
            @(negedge clk);
            axi.bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int lat);
        int cyc;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        cyc = 0;
        while (!axi.arready && cyc < 20) begin @(negedge clk); cyc++; end
        if (!axi.arready) check_val("arready_timeout", {31'd0, axi.arready}, 32'd1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        lat = 1;
        while (!axi.rvalid && lat < 20) begin @(negedge clk); lat++; end
        if (!axi.rvalid) check_val("rvalid_timeout", {31'd0, axi.rvalid}, 32'd1);
        data = axi.rdata;
        resp = axi.rresp;
        @(negedge clk);
        axi.rready = 1'b0;
    endtask

    task automatic pulse_frame_done();
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr, br;
        int          lat, p0;

        reset = 1'b1; frame_done = 1'b0;
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_awready", {31'd0, axi.awready}, 32'd0);
        check_val("rst_bvalid", {31'd0, axi.bvalid}, 32'd0);
        check_val("rst_rvalid", {31'd0, axi.rvalid}, 32'd0);
        check_val("rst_commit_pulse", {31'd0, commit_pulse}, 32'd0);
        check_val("rst_zero0", zeroes_out[31:0], 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_awready", {31'd0, axi.awready}, 32'd1);
        check_val("idle_arready", {31'd0, axi.arready}, 32'd1);
        axi_read(c_A_CTRL, rd, rr, lat);
        check_val("rst_ctrl", rd, 32'h1);
        check_val("read_latency", lat, 32'd2);
        axi_read(c_A_STATUS, rd, rr, lat);
        check_val("rst_status", rd, exp_status(1'b0, 16'd0));

        // Shadow write with no frame_done
        axi_write(c_A_Z0, 32'h0001_0002, 4'hF, 0, 1'b1, br);
        check_val("z0_bresp", {30'd0, br}, 32'd0);
        axi_read(c_A_Z0, rd, rr, lat);
        check_val("z0_rdata", rd, 32'h0001_0002);
        check_val("z0_rresp", {30'd0, rr}, 32'd0);
        check_val("z0_active_before", zeroes_out[31:0], 32'd0);
        axi_read(c_A_STATUS, rd, rr, lat);
        check_val("status_pending", rd, exp_status(1'b1, 16'd0));

        // Commit on frame_done
        pulse_frame_done();
        check_val("commit_pulse_hi", {31'd0, commit_pulse}, 32'd1);
        check_val("z0_active_after", zeroes_out[31:0], 32'h0001_0002);
        @(negedge clk);
        check_val("commit_pulse_lo", {31'd0, commit_pulse}, 32'd0);
        axi_read(c_A_STATUS, rd, rr, lat);
        check_val("status_cleared", rd, exp_status(1'b0, 16'd1));

        // frame_done with nothing pending: no commit
        p0 = n_pulses;
        pulse_frame_done();
        repeat (2) @(negedge clk);
        check_val("no_commit_idle", n_pulses, p0);

        // AW two cycles ahead of W, single byte strobe
        axi_write(c_A_Z1, 32'hAABB_CCDD, 4'b0100, 2, 1'b1, br);
        check_val("z1_bresp", {30'd0, br}, 32'd0);
        axi_read(c_A_Z1, rd, rr, lat);
        check_val("z1_strobe", rd, 32'h00BB_0000);

        // Out-of-range and read-only targets
        axi_write(c_A_BAD, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, br);
        check_val("bad_bresp", {30'd0, br}, 32'd2);
        axi_read(c_A_BAD, rd, rr, lat);
        check_val("bad_rresp", {30'd0, rr}, 32'd2);
        check_val("bad_rdata", rd, 32'd0);
        axi_write(c_A_STATUS, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, br);
        check_val("status_wr_bresp", {30'd0, br}, 32'd2);
        axi_read(c_A_Z0, rd, rr, lat);
        check_val("z0_untouched", rd, 32'h0001_0002);
        check_val("z1_active_hold", zeroes_out[63:32], 32'd0);
        pulse_frame_done();
        @(negedge clk);
        check_val("z1_active_commit", zeroes_out[63:32], 32'h00BB_0000);

        // commit_en = 0: frame_done ignored, force_commit still works
        axi_write(c_A_CTRL, 32'h0, 4'hF, 0, 1'b1, br);
        axi_write(c_A_P0, 32'h1234_5678, 4'hF, 0, 1'b1, br);
        repeat (2) @(negedge clk);
        p0 = n_pulses;
        repeat (3) begin
            pulse_frame_done();
            @(negedge clk);
        end
        @(negedge clk);
        check_val("cen0_no_pulse", n_pulses, p0);
        check_val("cen0_pole_hold", poles_out[31:0], 32'd0);
        axi_write(c_A_CTRL, 32'h2, 4'hF, 0, 1'b1, br);
        check_val("force_pole", poles_out[31:0], 32'h1234_5678);
        @(negedge clk);
        check_val("force_one_pulse", n_pulses, p0 + 1);
        axi_read(c_A_CTRL, rd, rr, lat);
        check_val("ctrl_after_force", rd, 32'h0);
        axi_read(c_A_STATUS, rd, rr, lat);
        check_val("status_after_force", rd, exp_status(1'b0, 16'd3));

        // Reset while a write response is outstanding
        axi_write(c_A_Z0, 32'hDEAD_0000, 4'hF, 0, 1'b0, br);
        check_val("pre_rst_bvalid", {31'd0, axi.bvalid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_drops_bvalid", {31'd0, axi.bvalid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_clears_active", zeroes_out[31:0], 32'd0);
        axi_read(c_A_Z0, rd, rr, lat);
        check_val("rst_clears_shadow", rd, 32'd0);
        axi_read(c_A_CTRL, rd, rr, lat);
        check_val("rst_ctrl_again", rd, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
